// File: rtl/uart_send.sv
// UART transmitter: one-entry holding register feeding an 8-bit serialiser.
// Start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
module uart_send #(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 9600,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BPS_CNT - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR_BIT,
        STOP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    idx;
    logic [2:0]    idx_nxt;
    logic          stop_idx;
    logic          stop_nxt;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;
    logic [7:0]    hold_data;
    logic          hold_full;
    logic          txd_nxt;
    logic          bit_end;
    logic          last_stop;
    logic          load;
    logic          accept;

    assign tx_ready  = ~hold_full;
    assign accept    = tx_valid & ~hold_full;
    assign bit_end   = (state != IDLE) && (cnt == CNT_MAX);
    assign last_stop = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
    // Loading on the last stop edge is what removes the idle gap between frames.
    assign load      = hold_full && ((state == IDLE) || last_stop);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        stop_nxt  = stop_idx;
        shift_nxt = load ? hold_data : shift;
        if (state == IDLE) begin
            cnt_nxt = '0;
        end else if (bit_end) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
        unique case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    idx_nxt   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == 3'd7) begin
                        state_nxt = (PARITY != 0) ? PAR_BIT : STOP;
                        stop_nxt  = 1'b0;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            PAR_BIT: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    stop_nxt  = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_idx == STOP_LAST) begin
                        state_nxt = load ? START : IDLE;
                    end else begin
                        stop_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so uart_txd is a clean flop.
    always_comb begin
        txd_nxt = 1'b1;
        unique case (1'b1)
            (state_nxt == START):   txd_nxt = 1'b0;
            (state_nxt == DATA):    txd_nxt = shift_nxt[idx_nxt];
            (state_nxt == PAR_BIT): txd_nxt = (PARITY == 1) ? ~^shift_nxt : ^shift_nxt;
            default:                txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= 3'd0;
            stop_idx <= 1'b0;
            shift    <= 8'd0;
            uart_txd <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            stop_idx <= stop_nxt;
            shift    <= shift_nxt;
            uart_txd <= txd_nxt;
            tx_busy  <= (state_nxt != IDLE);
            tx_done  <= last_stop;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold_full <= 1'b0;
            hold_data <= 8'd0;
        end else if (load) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_send.sv
// Bench for uart_send: three configurations, frame-level reference model
// comparing every line cycle against the expected bit sequence.
module tb_uart_send;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       valid [3];
    logic [7:0] data [3];
    wire        rdy0, rdy1, rdy2;
    wire        txd0, txd1, txd2;
    wire        busy0, busy1, busy2;
    wire        done0, done1, done2;

    int cyc = 0;
    int vecs = 0;
    int errs = 0;
    int dc0 = 0;
    logic [7:0] exp_q[$];
    int         acc_q[$];
    int         fstart[$];
    int         fend[$];
    logic [7:0] dec_q[$];
    logic       last_par;

    always #10 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;
    always @(negedge sys_clk) if (done0 === 1'b1) dc0 <= dc0 + 1;

    uart_send #(.CLK_FREQ(50000000), .UART_BPS(115200), .PARITY(0), .STOP_BITS(1)) u0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_valid(valid[0]), .tx_data(data[0]),
        .tx_ready(rdy0), .uart_txd(txd0), .tx_busy(busy0), .tx_done(done0));
    uart_send #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(1), .STOP_BITS(2)) u1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_valid(valid[1]), .tx_data(data[1]),
        .tx_ready(rdy1), .uart_txd(txd1), .tx_busy(busy1), .tx_done(done1));
    uart_send #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(2), .STOP_BITS(1)) u2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_valid(valid[2]), .tx_data(data[2]),
        .tx_ready(rdy2), .uart_txd(txd2), .tx_busy(busy2), .tx_done(done2));

    function automatic logic get_txd(input int u);
        return (u == 0) ? txd0 : (u == 1) ? txd1 : txd2;
    endfunction
    function automatic logic get_rdy(input int u);
        return (u == 0) ? rdy0 : (u == 1) ? rdy1 : rdy2;
    endfunction
    function automatic logic get_busy(input int u);
        return (u == 0) ? busy0 : (u == 1) ? busy1 : busy2;
    endfunction
    function automatic logic get_done(input int u);
        return (u == 0) ? done0 : (u == 1) ? done1 : done2;
    endfunction
    function automatic int bps_of(input int u);
        return (u == 0) ? 434 : 10;
    endfunction
    function automatic int par_of(input int u);
        return u;
    endfunction
    function automatic int stop_of(input int u);
        return (u == 1) ? 2 : 1;
    endfunction

    // Offer one byte at a negedge; returns at the negedge after the accept edge.
    task automatic drive(input int u, input logic [7:0] d, input bit noise);
        int n;
        n = 0;
        valid[u] = 1'b1;
        data[u] = d;
        while (get_rdy(u) !== 1'b1 && n < 20000) begin
            @(negedge sys_clk);
            n++;
            data[u] = noise ? 8'($urandom) : d;
        end
        if (n >= 20000) begin
            vecs++;
            errs++;
            $display("FAIL ready_timeout u%0d: tx_ready stayed %b, want 1", u, get_rdy(u));
            valid[u] = 1'b0;
            return;
        end
        data[u] = d;
        exp_q.push_back(d);
        acc_q.push_back(cyc + 1);
        @(negedge sys_clk);
        if (noise) data[u] = 8'($urandom);
    endtask

    task automatic check_frames(input int u, input int n);
        int bps, len, w, start, prev_end, acc, exp_st;
        int bad_wave, bad_busy, bad_done, bad_idle, first_bad;
        logic [7:0] d, dec;
        logic par_s, b2b;
        bit fb[$];
        bps = bps_of(u);
        prev_end = -1;
        fstart.delete();
        fend.delete();
        dec_q.delete();
        for (int f = 0; f < n; f++) begin
            w = 0;
            bad_idle = 0;
            while (get_txd(u) !== 1'b0 && w < 20000) begin
                @(negedge sys_clk);
                w++;
                if (get_done(u) !== 1'b0 && get_txd(u) !== 1'b0) bad_idle++;
            end
            vecs++;
            if (w >= 20000) begin
                errs++;
                $display("FAIL start_timeout u%0d f%0d: no start bit in %0d cycles", u, f, w);
                return;
            end
            if (bad_idle != 0) begin
                errs++;
                $display("FAIL idle_done u%0d f%0d: done high %0d idle cycles, want 0", u, f, bad_idle);
            end
            start = cyc;
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_frame u%0d f%0d: start at %0d, want none", u, f, start);
                return;
            end
            d = exp_q.pop_front();
            acc = acc_q.pop_front();
            exp_st = (acc < prev_end) ? prev_end : acc + 1;
            vecs++;
            if (start != exp_st) begin
                errs++;
                $display("FAIL start_cycle u%0d f%0d: got %0d, want %0d", u, f, start, exp_st);
            end
            vecs++;
            if (get_done(u) !== (prev_end == start)) begin
                errs++;
                $display("FAIL done_at_start u%0d f%0d: got %b, want %b",
                         u, f, get_done(u), prev_end == start);
            end
            fb.delete();
            fb.push_back(1'b0);
            for (int i = 0; i < 8; i++) fb.push_back(d[i]);
            if (par_of(u) == 1) fb.push_back(($countones(d) % 2) == 0);
            if (par_of(u) == 2) fb.push_back(($countones(d) % 2) == 1);
            for (int i = 0; i < stop_of(u); i++) fb.push_back(1'b1);
            len = fb.size() * bps;
            bad_wave = 0;
            bad_busy = 0;
            bad_done = 0;
            first_bad = -1;
            dec = 8'd0;
            par_s = 1'b0;
            for (int c = 0; c < len; c++) begin
                if (get_txd(u) !== fb[c / bps]) begin
                    bad_wave++;
                    if (first_bad < 0) first_bad = c;
                end
                if (get_busy(u) !== 1'b1) bad_busy++;
                if (c > 0 && get_done(u) !== 1'b0) bad_done++;
                if (c % bps == bps / 2) begin
                    if (c / bps >= 1 && c / bps <= 8) dec[c / bps - 1] = get_txd(u);
                    if (par_of(u) != 0 && c / bps == 9) par_s = get_txd(u);
                end
                @(negedge sys_clk);
            end
            b2b = (acc_q.size() > 0) && (acc_q[0] < cyc);
            vecs++;
            if (bad_wave != 0) begin
                errs++;
                $display("FAIL waveform u%0d f%0d: %0d bad cycles (first +%0d), want 0",
                         u, f, bad_wave, first_bad);
            end
            vecs++;
            if (bad_busy != 0) begin
                errs++;
                $display("FAIL busy_in_frame u%0d f%0d: low %0d cycles, want 0", u, f, bad_busy);
            end
            vecs++;
            if (bad_done != 0) begin
                errs++;
                $display("FAIL done_in_frame u%0d f%0d: high %0d cycles, want 0", u, f, bad_done);
            end
            vecs++;
            if (get_done(u) !== 1'b1) begin
                errs++;
                $display("FAIL done_end u%0d f%0d: got %b, want 1", u, f, get_done(u));
            end
            vecs++;
            if (get_busy(u) !== b2b) begin
                errs++;
                $display("FAIL busy_end u%0d f%0d: got %b, want %b", u, f, get_busy(u), b2b);
            end
            vecs++;
            if (dec !== d) begin
                errs++;
                $display("FAIL decode u%0d f%0d: got %h, want %h", u, f, dec, d);
            end
            fstart.push_back(start);
            fend.push_back(cyc);
            dec_q.push_back(dec);
            last_par = par_s;
            prev_end = cyc;
        end
        @(negedge sys_clk);
        vecs++;
        if (get_done(u) !== 1'b0) begin
            errs++;
            $display("FAIL done_width u%0d: got %b one cycle after pulse, want 0", u, get_done(u));
        end
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            valid[u] = 1'b0;
            data[u] = 8'd0;
        end
        repeat (3) @(negedge sys_clk);
        for (int u = 0; u < 3; u++) begin
            vecs += 4;
            if (get_txd(u) !== 1'b1) begin
                errs++;
                $display("FAIL rst_txd u%0d: got %b, want 1", u, get_txd(u));
            end
            if (get_rdy(u) !== 1'b1) begin
                errs++;
                $display("FAIL rst_ready u%0d: got %b, want 1", u, get_rdy(u));
            end
            if (get_busy(u) !== 1'b0) begin
                errs++;
                $display("FAIL rst_busy u%0d: got %b, want 0", u, get_busy(u));
            end
            if (get_done(u) !== 1'b0) begin
                errs++;
                $display("FAIL rst_done u%0d: got %b, want 0", u, get_done(u));
            end
        end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        drive(0, 8'hC3, 1'b0);
        drive(0, 8'h3A, 1'b0);
        valid[0] = 1'b0;
        repeat (1500) @(negedge sys_clk);
        vecs += 3;
        if (rdy0 !== 1'b0) begin
            errs++;
            $display("FAIL held_ready: got %b, want 0", rdy0);
        end
        if (busy0 !== 1'b1) begin
            errs++;
            $display("FAIL mid_busy: got %b, want 1", busy0);
        end
        if (txd0 !== 1'b0) begin
            errs++;
            $display("FAIL mid_txd: got %b, want 0 (bit d2 of C3)", txd0);
        end
        sys_rst_n = 1'b0;
        #1;
        vecs += 3;
        if (txd0 !== 1'b1) begin
            errs++;
            $display("FAIL midrst_txd: got %b, want 1", txd0);
        end
        if (rdy0 !== 1'b1) begin
            errs++;
            $display("FAIL midrst_ready: got %b, want 1", rdy0);
        end
        if (busy0 !== 1'b0) begin
            errs++;
            $display("FAIL midrst_busy: got %b, want 0", busy0);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(negedge sys_clk);
        fork
            begin
                drive(0, 8'($urandom), 1'b0);
                valid[0] = 1'b0;
            end
            check_frames(0, 1);
        join
    endtask

    task automatic test_single;
        int len;
        fork
            begin
                drive(0, 8'h55, 1'b0);
                valid[0] = 1'b0;
            end
            check_frames(0, 1);
        join
        len = (fend.size() == 1) ? fend[0] - fstart[0] : -1;
        vecs++;
        if (len != 4340) begin
            errs++;
            $display("FAIL single_len: start-to-done %0d cycles, want 4340", len);
        end
        fork
            begin
                for (int i = 0; i < 2; i++) begin
                    drive(0, 8'($urandom), 1'b0);
                    valid[0] = 1'b0;
                    repeat ($urandom_range(1, 4)) @(negedge sys_clk);
                end
            end
            check_frames(0, 2);
        join
    endtask

    task automatic test_back_to_back;
        int base;
        base = dc0;
        fork
            begin
                drive(0, 8'hA5, 1'b0);
                drive(0, 8'h3C, 1'b0);
                valid[0] = 1'b0;
            end
            check_frames(0, 2);
        join
        vecs += 3;
        if (fstart.size() != 2 || fstart[1] != fend[0]) begin
            errs++;
            $display("FAIL b2b_gap: second start %0d, want %0d", fstart.size() == 2 ? fstart[1] : -1,
                     fend.size() > 0 ? fend[0] : -1);
        end
        if (dec_q.size() != 2 || dec_q[0] !== 8'hA5 || dec_q[1] !== 8'h3C) begin
            errs++;
            $display("FAIL b2b_bytes: got %0d bytes, want A5 3C", dec_q.size());
        end
        if (dc0 - base != 2) begin
            errs++;
            $display("FAIL b2b_done_count: got %0d, want 2", dc0 - base);
        end
    endtask

    task automatic test_parity;
        int len;
        fork
            begin
                drive(1, 8'h07, 1'b0);
                valid[1] = 1'b0;
            end
            check_frames(1, 1);
        join
        vecs++;
        if (last_par !== 1'b0) begin
            errs++;
            $display("FAIL parity_odd: got %b, want 0", last_par);
        end
        fork
            begin
                drive(2, 8'h07, 1'b0);
                valid[2] = 1'b0;
            end
            check_frames(2, 1);
        join
        vecs += 2;
        if (last_par !== 1'b1) begin
            errs++;
            $display("FAIL parity_even: got %b, want 1", last_par);
        end
        len = (fend.size() == 1) ? fend[0] - fstart[0] : -1;
        if (len != 110) begin
            errs++;
            $display("FAIL parity_len: got %0d, want 110", len);
        end
    endtask

    task automatic test_stop_bits;
        int len;
        fork
            begin
                drive(1, 8'hFF, 1'b0);
                valid[1] = 1'b0;
            end
            check_frames(1, 1);
        join
        len = (fend.size() == 1) ? fend[0] - fstart[0] : -1;
        vecs++;
        if (len != 120) begin
            errs++;
            $display("FAIL stop2_len: got %0d, want 120", len);
        end
    endtask

    task automatic test_stall;
        fork
            begin
                drive(2, 8'($urandom), 1'b0);
                drive(2, 8'h00, 1'b1);
                drive(2, 8'hFF, 1'b1);
                drive(2, 8'h5A, 1'b1);
                valid[2] = 1'b0;
            end
            check_frames(2, 4);
        join
        vecs++;
        if (dec_q.size() != 4 || dec_q[1] !== 8'h00 || dec_q[2] !== 8'hFF || dec_q[3] !== 8'h5A) begin
            errs++;
            $display("FAIL stall_bytes: got %0d bytes, want 00 FF 5A after first", dec_q.size());
        end
    endtask

    task automatic test_random(input int u, input int n);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    int gap;
                    drive(u, 8'($urandom), 1'b0);
                    gap = $urandom_range(0, 30);
                    if (gap > 0) begin
                        valid[u] = 1'b0;
                        repeat (gap) @(negedge sys_clk);
                    end
                end
                valid[u] = 1'b0;
            end
            check_frames(u, n);
        join
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_parity;
        test_stop_bits;
        test_stall;
        test_random(1, 12);
        test_random(2, 12);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
